// File: rtl/filtered_uart_tx_if.sv
// Bus between the filter/controller side and the serial transmitter.
// master: the side that produces samples and control (controller or bench).
// slave : the transmitter itself.
interface filtered_uart_tx_if;
    logic        CLK_Filter;
    logic [19:0] Out_RED_Filtered;
    logic [19:0] Out_IR_Filtered;
    logic        Enable;
    logic        Clear_Overrun;
    logic        TX;
    logic        Busy;
    logic        Overrun;

    modport master (
        output CLK_Filter,
        output Out_RED_Filtered,
        output Out_IR_Filtered,
        output Enable,
        output Clear_Overrun,
        input  TX,
        input  Busy,
        input  Overrun
    );

    modport slave (
        input  CLK_Filter,
        input  Out_RED_Filtered,
        input  Out_IR_Filtered,
        input  Enable,
        input  Clear_Overrun,
        output TX,
        output Busy,
        output Overrun
    );
endinterface

// File: rtl/filtered_uart_tx.sv
// filtered_uart_tx: frames one RED/IR filter sample per CLK_Filter rising edge
// and sends it on a UART 8N1 line.
// Frame: SYNC, RED[19:16], RED[15:8], RED[7:0], IR[19:16], IR[15:8], IR[7:0].
// Optional build macro FRAME_CHECKSUM_EN appends an XOR checksum of the six
// payload bytes as an eighth byte.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, waiting for an accepted CLK_Filter edge
// START  | start bit (TX=0) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP   | stop bit (TX=1); then next byte's START or IDLE after last byte
module filtered_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic               CLK,
    input  logic               rst_n,
    filtered_uart_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd7;
`else
    localparam logic [2:0] LAST_BYTE = 3'd6;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state;
    logic             r_prev;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       r_byte_idx;
    logic [7:0]       r_shift;
    logic [19:0]      r_red;
    logic [19:0]      r_ir;
    logic             r_tx;
    logic             r_busy;
    logic             r_overrun;

    logic             w_edge;
    logic             w_accept;
    logic             w_drop;
    logic [7:0]       w_byte;

    assign w_edge   = bus.CLK_Filter & ~r_prev;
    assign w_accept = w_edge & bus.Enable & (r_state == S_IDLE);
    assign w_drop   = w_edge & bus.Enable & (r_state != S_IDLE);

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] w_csum;
    assign w_csum = {4'b0, r_red[19:16]} ^ r_red[15:8] ^ r_red[7:0]
                  ^ {4'b0, r_ir[19:16]}  ^ r_ir[15:8]  ^ r_ir[7:0];
`endif

    // Select the byte to send next from the held sample
    always_comb begin
        w_byte = SYNC_BYTE;
        case (r_byte_idx)
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = {4'b0, r_red[19:16]};
            3'd2:    w_byte = r_red[15:8];
            3'd3:    w_byte = r_red[7:0];
            3'd4:    w_byte = {4'b0, r_ir[19:16]};
            3'd5:    w_byte = r_ir[15:8];
            3'd6:    w_byte = r_ir[7:0];
`ifdef FRAME_CHECKSUM_EN
            3'd7:    w_byte = w_csum;
`endif
            default: w_byte = SYNC_BYTE;
        endcase
    end

    // Edge history, overrun flag and the framing FSM with registered TX/Busy
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_prev     <= 1'b1;  // a level already high at release is not an edge
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_red      <= '0;
            r_ir       <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_prev <= bus.CLK_Filter;

            // a drop in the same cycle as a clear still leaves the flag set
            if (w_drop)
                r_overrun <= 1'b1;
            else if (bus.Clear_Overrun)
                r_overrun <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_red      <= bus.Out_RED_Filtered;
                        r_ir       <= bus.Out_IR_Filtered;
                        r_busy     <= 1'b1;
                        r_tx       <= 1'b0;
                        r_byte_idx <= '0;
                        r_baud_cnt <= BAUD_LAST;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud_cnt == '0) begin
                        r_shift    <= w_byte;
                        r_tx       <= w_byte[0];
                        r_bit_cnt  <= '0;
                        r_baud_cnt <= BAUD_LAST;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud_cnt == '0) begin
                        r_baud_cnt <= BAUD_LAST;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (r_baud_cnt == '0) begin
                        if (r_byte_idx == LAST_BYTE) begin
                            r_busy     <= 1'b0;
                            r_byte_idx <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            // next byte starts immediately, no idle gap
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx       <= 1'b0;
                            r_baud_cnt <= BAUD_LAST;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - BAUD_ONE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.TX      = r_tx;
    assign bus.Busy    = r_busy;
    assign bus.Overrun = r_overrun;

endmodule

// File: doc/filtered_uart_tx.md
Name: filtered_uart_tx

Overview:
- Serial transmitter at the output end of the controller/FIR datapath.
- Detects each rising edge of CLK_Filter, captures the 20-bit RED and IR filtered samples, and frames them into bytes.
- Shifts the bytes out on a UART 8N1 line to the host/logging PC.
- One frame is sent per filter sample; samples that arrive while a frame is in flight are dropped and flagged.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per UART bit. Legal range is ≥2; the counter width is derived from it.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- CLK  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- CLK_Filter  input  1  sample strobe produced by the controller, a level synchronous to CLK. Its rising edge means new filtered data is valid.
- Out_RED_Filtered  input  20  RED FIR output, unsigned.
- Out_IR_Filtered  input  20  IR FIR output, unsigned.
- Enable  input  1  1 = accept new samples; 0 = ignore new edges and finish the current frame.
- Clear_Overrun  input  1  synchronous clear of Overrun.
- TX  output  1  UART line: idle high, LSB first, 1 start bit, 8 data bits, 1 stop bit.
- Busy  output  1  high while a frame is being transmitted.
- Overrun  output  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - TX=1, Busy=0, Overrun=0.
  - State IDLE, bit/byte/baud counters 0.
  - CLK_Filter history register set to 1, so a CLK_Filter held high at reset release is not an edge.
  - Reset mid-frame aborts the frame immediately. TX returns high with no partial stop bit.
- Edge detect: edge = CLK_Filter & ~prev, with prev registered every cycle.
- Accept rule:
  - The edge is accepted only when state==IDLE and Enable=1.
  - On acceptance, both inputs are latched into holding registers, Busy is set to 1, and state goes to START.
  - The edge is seen in cycle N; TX goes low from cycle N+1 (1-cycle latency).
- Edge while not IDLE and Enable=1: the sample is dropped and Overrun is set to 1 the next cycle. This includes an edge in the last cycle of the final stop bit.
- Edge with Enable=0: ignored; Overrun is not affected.
- Overrun:
  - Cleared by Clear_Overrun=1.
  - If a set and a clear happen in the same cycle, the set wins.
- Frame byte order (7 bytes):
  - SYNC_BYTE
  - {4'b0,RED[19:16]}, RED[15:8], RED[7:0]
  - {4'b0,IR[19:16]}, IR[15:8], IR[7:0]
- FSM states:
  - IDLE
  - START: TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, each CLKS_PER_BIT cycles, bit 0 first.
  - STOP: TX=1 for CLKS_PER_BIT cycles.
  - After STOP, if bytes remain: go to START for the next byte, with no idle gap. Otherwise go to IDLE.
- TX and Busy are registered outputs, with no combinational path from the inputs.
- Busy drops in the first cycle after the last stop bit completes. The same cycle may accept a new edge; Busy is then re-asserted the next cycle.
- Frame duration: bytes × 10 × CLKS_PER_BIT cycles.
- Holding registers stay stable for the whole frame. Input changes during a frame do not affect TX.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- When defined:
  - An 8th byte is appended: the XOR of the 6 payload bytes (SYNC excluded).
  - Frame = 8 bytes, 80×CLKS_PER_BIT cycles.
- When undefined:
  - The frame is 7 bytes and no checksum logic exists.
- Edge/overrun rules are identical in both builds.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, RED=20'h12345, IR=20'hABCDE, one CLK_Filter edge.
  - TX decodes A5 01 23 45 0A BC DE.
  - Busy is high for exactly 280 cycles, starting the cycle after the edge.
- Checksum build (FRAME_CHECKSUM_EN), same stimulus:
  - The bytes above followed by 0F.
  - Busy lasts 320 cycles.
- Overrun: second edge 100 cycles into the frame.
  - The frame is unchanged (second sample never sent).
  - Overrun=1 from the next cycle until a Clear_Overrun pulse.
  - Simultaneous edge-drop and clear leaves Overrun=1.
- Enable=0 edge: no frame, TX stays 1, Overrun stays 0. With Enable=0 mid-frame, the frame completes normally.
- Reset mid-frame: rst_n low during RED byte 2.
  - TX=1, Busy=0 asynchronously.
  - With CLK_Filter held high through reset release: no frame until the next true rising edge, which produces a complete fresh frame.
- Back-to-back: edge in the first cycle after Busy falls.
  - Accepted, with no Overrun.
  - The next start bit begins one cycle later.
